tt_um_addon_hypot: RTL and testbench



---
 rtl/tt_um_addon_hypot.sv | 87 ++++++++
 tb/tb_tt_um_addon_hypot.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/tt_um_addon_hypot.sv
// Integer hypotenuse engine: floor(sqrt(x*x + y*y)), saturated to 8 bits.
// Free-running load/square/restoring-root/done loop, one result per 12 clocks.
module tt_um_addon_hypot (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        LOAD,
        SQUARE,
        ROOT,
        DONE
    } state_t;

    state_t      state_q;
    logic [7:0]  x_q;
    logic [7:0]  y_q;
    logic [16:0] sum_q;
    logic [8:0]  root_q;
    logic [3:0]  cnt_q;

    logic [8:0]  cand;
    logic [17:0] cand_sq;
    logic [16:0] x_sq;
    logic [16:0] y_sq;
    logic        unused_ok;

    assign uio_out   = 8'h00;
    assign uio_oe    = 8'h00;
    assign unused_ok = ena;

    // 511^2 fits in 18 bits, so the candidate square never truncates
    always_comb begin
        cand    = root_q | (9'd1 << cnt_q);
        cand_sq = {9'd0, cand} * {9'd0, cand};
        x_sq    = {9'd0, x_q} * {9'd0, x_q};
        y_sq    = {9'd0, y_q} * {9'd0, y_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            sum_q   <= 17'd0;
            root_q  <= 9'd0;
            cnt_q   <= 4'd0;
            uo_out  <= 8'd0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    x_q     <= ui_in;
                    y_q     <= uio_in;
                    state_q <= SQUARE;
                end
                SQUARE: begin
                    sum_q   <= x_sq + y_sq;
                    root_q  <= 9'd0;
                    cnt_q   <= 4'd8;
                    state_q <= ROOT;
                end
                ROOT: begin
                    if (cand_sq <= {1'b0, sum_q}) begin
                        root_q <= cand;
                    end
                    if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    uo_out  <= root_q[8] ? 8'hFF : root_q[7:0];
                    state_q <= LOAD;
                end
                default: state_q <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_addon_hypot.sv
// Self-checking bench for tt_um_addon_hypot: behavioural model plus
// directed literal checks and randomized operand streams.
module tb_tt_um_addon_hypot;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b1;
    logic [7:0] ui_in  = 8'd0;
    logic [7:0] uio_in = 8'd0;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    int m_phase = 0;
    int m_x     = 0;
    int m_y     = 0;
    int m_out   = 0;

    tt_um_addon_hypot dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    function automatic int hyp(input int a, input int b);
        int s;
        int r;
        s = a * a + b * b;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return (r > 255) ? 255 : r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: capture every 12th edge after reset, publish 11 edges later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_out   = 0;
        end else begin
            if (m_phase == 0) begin
                m_x = int'(ui_in);
                m_y = int'(uio_in);
            end
            if (m_phase == 11) m_out = hyp(m_x, m_y);
            m_phase = (m_phase + 1) % 12;
        end
    end

    always @(negedge clk) begin
        check("uo_out_model", int'(uo_out), m_out);
        check("uio_out_zero", int'(uio_out), 0);
        check("uio_oe_zero", int'(uio_oe), 0);
    end

    task automatic window(input int x, input int y, input int lit, input string name);
        ui_in  = 8'(x);
        uio_in = 8'(y);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check(name, int'(uo_out), lit);
    endtask

    typedef struct {
        int x;
        int y;
        int r;
    } vec_t;

    vec_t vecs[10] = '{
        '{200, 150, 250}, '{5, 12, 13}, '{1, 1, 1}, '{10, 10, 14},
        '{0, 0, 0}, '{255, 0, 255}, '{0, 255, 255}, '{255, 255, 255},
        '{180, 181, 255}, '{3, 4, 5}
    };

    int edge_vals[6] = '{0, 1, 128, 180, 181, 255};

    initial begin
        check("model_3_4", hyp(3, 4), 5);
        check("model_200_150", hyp(200, 150), 250);
        check("model_10_10", hyp(10, 10), 14);
        check("model_255_255", hyp(255, 255), 255);
        check("model_180_181", hyp(180, 181), 255);

        ui_in  = 8'($urandom);
        uio_in = 8'($urandom);
        repeat (3) @(negedge clk);
        check("reset_uo_out", int'(uo_out), 0);
        ui_in  = 8'd3;
        uio_in = 8'd4;
        rst_n  = 1'b1;
        window(3, 4, 5, "basic_3_4");
        window(3, 4, 5, "basic_3_4_again");

        foreach (vecs[i]) window(vecs[i].x, vecs[i].y, vecs[i].r, "table");

        // Inputs changed after capture must not affect the running result
        ui_in  = 8'd3;
        uio_in = 8'd4;
        repeat (4) @(posedge clk);
        @(negedge clk);
        ui_in  = 8'd255;
        uio_in = 8'd255;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("holdoff_first", int'(uo_out), 5);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("holdoff_second", int'(uo_out), 255);

        window(3, 4, 5, "pre_reset_5");
        repeat (6) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("midreset_async", int'(uo_out), 0);
        ui_in  = 8'd6;
        uio_in = 8'd8;
        @(negedge clk);
        check("midreset_held", int'(uo_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        window(6, 8, 10, "post_reset_6_8");

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    ui_in  = 8'(edge_vals[$urandom_range(0, 5)]);
                    uio_in = 8'(edge_vals[$urandom_range(0, 5)]);
                end else begin
                    ui_in  = 8'($urandom);
                    uio_in = 8'($urandom);
                end
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
